reg_file: RTL and testbench
===========================

# reg_file

Architectural register file and hazard scoreboard at the receiving end of the writeback port. Accepts one register write per cycle from the writeback stage (data, write enable, destination address) and serves two combinational read ports to the decode stage. Tracks destination registers with writes still in flight and raises a stall request when decode reads one. Sits between decode (read/issue side) and writeback (write side) in the 5-stage pipeline.

## Interface
Parameters:
- none (32 registers × 32 bits, fixed)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- write_reg_data  in  32  writeback data
- Regwrite  in  1  writeback write enable, active-high
- write_reg_address  in  5  writeback destination register
- rs1_addr  in  5  decode read port 1 address
- rs2_addr  in  5  decode read port 2 address
- rs1_data  out  32  read port 1 data
- rs2_data  out  32  read port 2 data
- issue_valid  in  1  decode issuing an instruction that will write issue_rd
- issue_rd  in  5  destination of issuing instruction
- keep  in  1  pipeline hold; suppresses issue marking this cycle
- nop  in  1  flush; clears all pending-write marks
- stall  out  1  rs1 or rs2 has a pending write; decode must hold

## Operation
- Storage: regs[1..31], 32 bits each; x0 not stored, always reads 0x00000000.
- Write: on rising edge, if Regwrite=1 and write_reg_address≠0, regs[write_reg_address] ← write_reg_data. Writes to x0 discarded.
- Read: rs1_data/rs2_data combinational from rs1_addr/rs2_addr.
- Scoreboard busy[31:1]:
  - set: issue_valid=1, keep=0, nop=0, issue_rd≠0 → busy[issue_rd] ← 1 at edge.
  - clear: Regwrite=1, write_reg_address≠0 → busy[write_reg_address] ← 0 at edge.
  - same register set and cleared in same cycle: set wins (newer producer outstanding).
  - nop=1: all busy ← 0 at edge; register writes in that cycle still performed.
- stall = (rs1_addr≠0 & busy[rs1_addr]) | (rs2_addr≠0 & busy[rs2_addr]), plus bypass term per Configuration. x0 never stalls.
- Concurrent write to both read addresses: both ports return identical value.

## Timing
- Reset (rst=1 at edge): regs[1..31] ← 0, busy ← 0. After reset: rs1_data=rs2_data=0, stall=0. rst overrides Regwrite, issue and nop in that cycle.
- Write latency: stored value visible on read ports the cycle after the write edge (without bypass); same cycle with bypass.
- Scoreboard: busy set at edge N (issue) → stall asserted from cycle N+1 while decode reads that register; cleared at writeback edge M → stall deasserts in cycle M+1 (cycle M with bypass, since bypass supplies data).
- stall purely combinational from current busy state and read addresses; no registered output.
- Reset asserted mid-operation: pending writes lost, all busy bits cleared at that edge.

## Configuration
- REGFILE_BYPASS_EN defined: write-through bypass. If Regwrite=1 and write_reg_address equals a nonzero read address, that read port returns write_reg_data in the same cycle, and the busy bit of that address is ignored for stall in that cycle (unless also re-set by issue, which affects only later cycles).
- Not defined: read ports return stored value only; stall additionally asserted when Regwrite=1 and write_reg_address (≠0) equals rs1_addr or rs2_addr, holding decode one cycle until the write lands.

## Test plan
- Reset then read all 32 addresses → every read 0x00000000, stall=0.
- Write x5=0xDEADBEEF, next cycle read rs1=5, rs2=0 → rs1_data=0xDEADBEEF, rs2_data=0; write x0=0x1234 → x0 still reads 0.
- Issue rd=7, then read rs2=7 for 3 cycles → stall=1; Regwrite to x7=0x55 → stall=0 next cycle, rs2_data=0x55.
- Same-cycle write x3=0xA5A5A5A5 with rs1=rs2=3 → REGFILE_BYPASS_EN: both 0xA5A5A5A5, stall=0; without: old value, stall=1 for one cycle.
- Issue rd=9 in same cycle as writeback to x9 → busy[9] remains set, stall=1 on read of x9; issue with keep=1 → no busy set.
- Mark x4, x6 busy, assert nop → stall=0 next cycle for reads of 4 and 6; assert rst with Regwrite to x4 → x4 reads 0.

Source files
------------

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_if
//  Description : Writeback, decode read/issue and stall signals of reg_file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if;
   logic [31:0] write_reg_data;
   logic        Regwrite;
   logic [4:0]  write_reg_address;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        keep;
   logic        nop;
   logic        stall;

   modport master (
      output write_reg_data, Regwrite, write_reg_address,
      output rs1_addr, rs2_addr, issue_valid, issue_rd, keep, nop,
      input  rs1_data, rs2_data, stall
   );

   modport slave (
      input  write_reg_data, Regwrite, write_reg_address,
      input  rs1_addr, rs2_addr, issue_valid, issue_rd, keep, nop,
      output rs1_data, rs2_data, stall
   );
endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : 32x32 register file, two combinational read ports and a
//                pending-write scoreboard driving a decode stall request.
//                Optional macro REGFILE_BYPASS_EN enables write-through bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file (
   input  wire logic  clk,
   input  wire logic  rst,
   reg_file_if.slave  rf
);
   logic [31:0] r_regs [1:31];
   logic [31:1] r_busy;
   logic [31:1] w_busy_next;
   logic [31:0] w_busy_ext;
   logic        w_wr_en;
   logic        w_issue;
   logic [31:0] w_stored1;
   logic [31:0] w_stored2;
   logic        w_hit1;
   logic        w_hit2;
   logic        w_stall1;
   logic        w_stall2;

   assign w_wr_en = rf.Regwrite && (rf.write_reg_address != 5'd0);
   assign w_issue = rf.issue_valid && !rf.keep && !rf.nop && (rf.issue_rd != 5'd0);

   // Clear before set so an issue to the register being written back wins:
   // the newer producer is still outstanding.
   always_comb begin
      w_busy_next = r_busy;
      if (w_wr_en) begin
         w_busy_next[rf.write_reg_address] = 1'b0;
      end
      if (w_issue) begin
         w_busy_next[rf.issue_rd] = 1'b1;
      end
      if (rf.nop) begin
         w_busy_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < 32; i++) begin
            r_regs[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         if (w_wr_en) begin
            r_regs[rf.write_reg_address] <= rf.write_reg_data;
         end
         r_busy <= w_busy_next;
      end
   end

   // Bit 0 tied low so x0 can be looked up without a special case.
   assign w_busy_ext = {r_busy, 1'b0};

   assign w_stored1 = (rf.rs1_addr == 5'd0) ? 32'd0 : r_regs[rf.rs1_addr];
   assign w_stored2 = (rf.rs2_addr == 5'd0) ? 32'd0 : r_regs[rf.rs2_addr];
   assign w_hit1    = w_wr_en && (rf.write_reg_address == rf.rs1_addr);
   assign w_hit2    = w_wr_en && (rf.write_reg_address == rf.rs2_addr);

`ifdef REGFILE_BYPASS_EN
   assign rf.rs1_data = w_hit1 ? rf.write_reg_data : w_stored1;
   assign rf.rs2_data = w_hit2 ? rf.write_reg_data : w_stored2;
   assign w_stall1    = w_busy_ext[rf.rs1_addr] && !w_hit1;
   assign w_stall2    = w_busy_ext[rf.rs2_addr] && !w_hit2;
`else
   // Without bypass, hold decode for the cycle in which its operand lands.
   assign rf.rs1_data = w_stored1;
   assign rf.rs2_data = w_stored2;
   assign w_stall1    = w_busy_ext[rf.rs1_addr] || w_hit1;
   assign w_stall2    = w_busy_ext[rf.rs2_addr] || w_hit2;
`endif

   assign rf.stall = w_stall1 || w_stall2;
endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Randomized and directed scoreboard bench for reg_file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_file_if rf ();
   reg_file dut (.clk(clk), .rst(rst), .rf(rf));

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic        st;
      logic [4:0]  a1;
      logic [4:0]  a2;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_regs [0:31];
   bit          m_busy [0:31];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check($sformatf("rs1_data[x%0d]", e.a1), rf.rs1_data, e.d1);
         check($sformatf("rs2_data[x%0d]", e.a2), rf.rs2_data, e.d2);
         check($sformatf("stall[x%0d,x%0d]", e.a1, e.a2), {31'd0, rf.stall}, {31'd0, e.st});
      end
   end

   function automatic logic [31:0] exp_read(input logic [4:0] a, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
      logic [31:0] v;
      v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
      if (we && wa != 0 && wa == a) v = wd;
`endif
      return v;
   endfunction

   function automatic bit exp_stall_port(input logic [4:0] a, input logic we, input logic [4:0] wa);
      bit pending;
      bit landing;
      pending = (a != 0) && m_busy[a];
      landing = we && (wa != 0) && (wa == a);
`ifdef REGFILE_BYPASS_EN
      return pending && !landing;
`else
      return pending || landing;
`endif
   endfunction

   // One clock of stimulus: expectation from the current model, then model advance.
   task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic iv, input logic [4:0] ird, input logic kp, input logic nf);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      rf.Regwrite = we; rf.write_reg_address = wa; rf.write_reg_data = wd;
      rf.rs1_addr = a1; rf.rs2_addr = a2;
      rf.issue_valid = iv; rf.issue_rd = ird; rf.keep = kp; rf.nop = nf;
      if (!r) begin
         e.d1 = exp_read(a1, we, wa, wd);
         e.d2 = exp_read(a2, we, wa, wd);
         e.st = exp_stall_port(a1, we, wa) | exp_stall_port(a2, we, wa);
         e.a1 = a1;
         e.a2 = a2;
         exp_q.push_back(e);
      end
      if (r) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (we && wa != 0) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
         end
         if (iv && !kp && !nf && ird != 0) m_busy[ird] = 1'b1;
         if (nf) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         end
      end
   endtask

   task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
      step(0, 0, 0, 0, a1, a2, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      rf.Regwrite = 0; rf.write_reg_address = 0; rf.write_reg_data = 0;
      rf.rs1_addr = 0; rf.rs2_addr = 0;
      rf.issue_valid = 0; rf.issue_rd = 0; rf.keep = 0; rf.nop = 0;
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end

      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 5'd3, 32'h1111, 0, 0, 1, 5'd3, 0, 0);
      for (int i = 0; i < 32; i++) idle_read(5'(i), 5'(31 - i));

      // Write/read and x0 discard
      step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
      idle_read(5'd5, 5'd0);
      step(0, 1, 5'd0, 32'h1234, 0, 0, 0, 0, 0, 0);
      idle_read(5'd0, 5'd0);

      // Issue hazard and its writeback
      step(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
      for (int i = 0; i < 3; i++) idle_read(5'd1, 5'd7);
      step(0, 1, 5'd7, 32'h55, 5'd1, 5'd7, 0, 0, 0, 0);
      idle_read(5'd1, 5'd7);

      // Same-cycle write to both read addresses
      step(0, 1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 0, 0, 0, 0);
      idle_read(5'd3, 5'd3);

      // Set wins over clear; keep suppresses issue
      step(0, 1, 5'd9, 32'h99, 0, 0, 1, 5'd9, 0, 0);
      idle_read(5'd9, 5'd0);
      step(0, 0, 0, 0, 0, 0, 1, 5'd10, 1, 0);
      idle_read(5'd10, 5'd10);

      // nop flush, then reset overriding a write
      step(0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 5'd6, 0, 0);
      idle_read(5'd4, 5'd6);
      step(0, 1, 5'd4, 32'h4444, 5'd4, 5'd6, 1, 5'd6, 0, 1);
      idle_read(5'd4, 5'd6);
      step(1, 1, 5'd4, 32'hCAFE, 0, 0, 0, 0, 0, 0);
      idle_read(5'd4, 5'd9);

      // Randomized traffic, addresses biased toward a small set to provoke hazards
      for (int n = 0; n < 600; n++) begin
         logic [4:0] wa, a1, a2, ird;
         bit narrow;
         narrow = ($urandom_range(0, 3) != 0);
         wa  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         a1  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         a2  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         ird = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         step(($urandom_range(0, 149) == 0), 1'($urandom), wa, $urandom, a1, a2,
              1'($urandom), ird, ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
      end

      idle_read(0, 0);
      repeat (3) @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
